// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - issue/hazard controller between decode and the execute-stage ALU
// Stalls on RAW hazards against in-flight writers, holds issue while a branch resolves, drains on HALT.
module ex_issue_ctrl #(
  parameter int DEPTH   = 3,
  parameter int BR_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [5:0]  id_op,
  input  logic [4:0]  id_rs_add,
  input  logic [4:0]  id_rt_add,
  input  logic [4:0]  id_rd_add,
  output logic        issue,
  output logic        id_stall,
  output logic [5:0]  ex_op,
  output logic        br_resolve,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] issue_count,
  output logic [31:0] stall_count
);

  localparam int CW = (BR_WAIT < 2) ? 1 : $clog2(BR_WAIT + 1);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_BRW  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t             st;
  logic [CW-1:0]      brw_cnt;
  logic [DEPTH-1:0]   trk_v;
  logic [4:0]         trk_d [DEPTH];

  logic uses_rs, uses_rt, writes_rd, is_br, is_halt, hazard, stall_inc;

  always_comb begin
    uses_rs   = 1'b0;
    uses_rt   = 1'b0;
    writes_rd = 1'b0;
    is_br     = 1'b0;
    is_halt   = 1'b0;
    case (id_op)
      6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b001000, 6'b001010: begin
        uses_rs = 1'b1; uses_rt = 1'b1; writes_rd = 1'b1;
      end
      6'b000001, 6'b000011, 6'b000101, 6'b000111, 6'b001001, 6'b001011, 6'b001100: begin
        uses_rs = 1'b1; writes_rd = 1'b1;
      end
      6'b001101: begin
        uses_rs = 1'b1; uses_rt = 1'b1;
      end
      6'b001111: begin
        uses_rs = 1'b1; uses_rt = 1'b1; is_br = 1'b1;
      end
      6'b001110, 6'b010000: begin
        uses_rs = 1'b1; is_br = 1'b1;
      end
      6'b010001: is_halt = 1'b1;
      default: ;
    endcase
  end

  // The oldest slot is in WB; the register file writes before it is read, so it cannot hazard.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (trk_v[i] && ((uses_rs && trk_d[i] == id_rs_add) ||
                       (uses_rt && trk_d[i] == id_rt_add)))
        hazard = 1'b1;
    end
  end

  assign issue     = id_valid && (st == S_RUN) && !hazard;
  assign id_stall  = id_valid && !issue && (st != S_HALT);
  assign stall_inc = id_stall;
  assign ex_op     = issue ? id_op : 6'b111111;
  assign halted    = (st == S_HALT) && (trk_v == '0);
  assign state     = st;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_v <= '0;
      for (int i = 0; i < DEPTH; i++) trk_d[i] <= 5'd0;
    end else begin
      trk_v[0] <= issue && writes_rd;
      trk_d[0] <= id_rd_add;
      for (int i = 1; i < DEPTH; i++) begin
        trk_v[i] <= trk_v[i-1];
        trk_d[i] <= trk_d[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st         <= S_RUN;
      brw_cnt    <= '0;
      br_resolve <= 1'b0;
    end else begin
      br_resolve <= issue && is_br;
      case (st)
        S_RUN: begin
          if (issue && is_br) begin
            st      <= S_BRW;
            brw_cnt <= CW'(BR_WAIT);
          end else if (issue && is_halt) begin
            st <= S_HALT;
          end
        end
        S_BRW: begin
          brw_cnt <= brw_cnt - 1'b1;
          if (brw_cnt == CW'(1)) st <= S_RUN;
        end
        S_HALT: ;
        default: st <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_count <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (issue && issue_count != 32'hFFFF_FFFF) issue_count <= issue_count + 32'd1;
      if (stall_inc && stall_count != 32'hFFFF_FFFF) stall_count <= stall_count + 32'd1;
    end
  end

endmodule
